// File: rtl/lsu_mem_master_pkg.sv
// Shared types and helpers for the load/store byte-sequencing master.
package lsu_mem_master_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 4;

   typedef enum logic [2:0] {
      MT_B  = 3'b000,
      MT_H  = 3'b001,
      MT_W  = 3'b010,
      MT_BU = 3'b011,
      MT_HU = 3'b100
   } mem_type_e;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      RESP
   } lsu_state_e;

   typedef struct packed {
      logic              we;
      mem_type_e         mtype;
      logic [DATA_W-1:0] wdata;
   } lsu_req_t;

   // Number of single-byte memory accesses for an access type.
   function automatic logic [2:0] nbytes(input mem_type_e mtype);
      case (mtype)
         MT_H, MT_HU: nbytes = 3'd2;
         MT_W:        nbytes = 3'd4;
         default:     nbytes = 3'd1;
      endcase
   endfunction

   // Unsigned stores are meaningless, and codes above MT_HU are undefined.
   function automatic bit legal(input logic we, input logic [2:0] mtype);
      bit known;
      bit ustore;
      known  = (mtype <= 3'(MT_HU));
      ustore = we && ((mtype == 3'(MT_BU)) || (mtype == 3'(MT_HU)));
      legal  = known && !ustore;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Pipeline-side request/response handshake of the load/store master.
interface lsu_mem_master_if;
   import lsu_mem_master_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_type;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              busy;

   modport master (
      output req_valid, req_we, req_type, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_type, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );

endinterface

// File: rtl/lsu_mem_master_extend.sv
// Sign/zero extension of assembled little-endian load bytes.
module lsu_mem_master_extend
   import lsu_mem_master_pkg::*;
(
   input  mem_type_e         mtype,
   input  logic [DATA_W-1:0] raw,
   output logic [DATA_W-1:0] extended_c
);

   always_comb begin
      extended_c = '0;
      case (mtype)
         MT_B:    extended_c = {{24{raw[7]}}, raw[7:0]};
         MT_H:    extended_c = {{16{raw[15]}}, raw[15:0]};
         MT_W:    extended_c = raw;
         MT_BU:   extended_c = {24'd0, raw[7:0]};
         MT_HU:   extended_c = {16'd0, raw[15:0]};
         default: extended_c = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one pipeline request becomes 1/2/4 byte accesses to a byte-wide memory.
module lsu_mem_master
   import lsu_mem_master_pkg::*;
#(
   parameter int unsigned ADDR_W = 5
)
(
   input  logic              clk,
   input  logic              rst,
   lsu_mem_master_if.slave   req_if,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   lsu_state_e             state;
   lsu_req_t               req_q;
   logic [1:0]             cnt;
   logic [1:0]             cnt_nxt;
   logic [LANES-1:0][7:0]  cap;
   logic [LANES-1:0][7:0]  raw_c;
   logic [DATA_W-1:0]      ext_c;
   logic                   accept_c;
   logic                   legal_c;
   logic                   last_c;
   logic                   unused_addr_c;

   assign accept_c      = req_if.req_valid && req_if.req_ready;
   assign legal_c       = legal(req_if.req_we, req_if.req_type);
   assign cnt_nxt       = cnt + 2'd1;
   assign last_c        = (({1'b0, cnt}) + 3'd1) == nbytes(req_q.mtype);
   assign unused_addr_c = ^req_if.req_addr[DATA_W-1:ADDR_W];

   // The final byte arrives in the same cycle the response is formed, so merge it in directly.
   always_comb begin
      raw_c      = cap;
      raw_c[cnt] = mem_rdata;
   end

   lsu_mem_master_extend u_extend (
      .mtype      (req_q.mtype),
      .raw        (raw_c),
      .extended_c (ext_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         req_q             <= '0;
         cnt               <= '0;
         cap               <= '0;
         mem_rd_en         <= 1'b0;
         mem_wr_en         <= 1'b0;
         mem_addr          <= '0;
         mem_wdata         <= '0;
         req_if.req_ready  <= 1'b1;
         req_if.resp_valid <= 1'b0;
         req_if.resp_rdata <= '0;
         req_if.resp_err   <= 1'b0;
         req_if.busy       <= 1'b0;
      end else begin
         case (state)
            IDLE, RESP: begin
               req_if.resp_valid <= 1'b0;
               req_if.resp_err   <= 1'b0;
               req_if.resp_rdata <= '0;
               if (accept_c) begin
                  cnt         <= '0;
                  cap         <= '0;
                  req_if.busy <= 1'b1;
                  if (legal_c) begin
                     // First byte goes out in the very first XFER cycle.
                     state            <= XFER;
                     req_q            <= '{we:    req_if.req_we,
                                           mtype: mem_type_e'(req_if.req_type),
                                           wdata: req_if.req_wdata};
                     req_if.req_ready <= 1'b0;
                     mem_rd_en        <= !req_if.req_we;
                     mem_wr_en        <= req_if.req_we;
                     mem_addr         <= req_if.req_addr[ADDR_W-1:0];
                     mem_wdata        <= req_if.req_wdata[7:0];
                  end else begin
                     state             <= RESP;
                     req_if.req_ready  <= 1'b1;
                     req_if.resp_valid <= 1'b1;
                     req_if.resp_err   <= 1'b1;
                  end
               end else begin
                  state            <= IDLE;
                  req_if.req_ready <= 1'b1;
                  req_if.busy      <= 1'b0;
               end
            end

            XFER: begin
               if (!req_q.we) begin
                  cap[cnt] <= mem_rdata;
               end
               if (last_c) begin
                  state             <= RESP;
                  cnt               <= '0;
                  mem_rd_en         <= 1'b0;
                  mem_wr_en         <= 1'b0;
                  mem_wdata         <= '0;
                  req_if.req_ready  <= 1'b1;
                  req_if.resp_valid <= 1'b1;
                  req_if.resp_err   <= 1'b0;
                  req_if.resp_rdata <= req_q.we ? '0 : ext_c;
               end else begin
                  cnt       <= cnt_nxt;
                  mem_addr  <= mem_addr + ADDR_W'(1);
                  mem_wdata <= req_q.wdata[{cnt_nxt, 3'b000} +: 8];
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench: per-cycle compare against a transaction-level model plus literal pins.
module tb_lsu_mem_master;

   localparam int unsigned AW    = 5;
   localparam int          DEPTH = 32;
   localparam int          MAXC  = 1024;
   localparam int          LITN  = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   lsu_mem_master_if bus ();

   logic          mem_rd_en;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   logic [7:0] tb_mem    [DEPTH];
   logic [7:0] model_mem [DEPTH];

   int cyc = 0;

   bit          exp_ready [MAXC];
   bit          exp_busy  [MAXC];
   bit          exp_rd    [MAXC];
   bit          exp_wr    [MAXC];
   logic [AW-1:0] exp_addr [MAXC];
   logic [7:0]  exp_wdata [MAXC];
   bit          exp_rv    [MAXC];
   bit          exp_err   [MAXC];
   logic [31:0] exp_rdata [MAXC];

   int free_at = 0;
   bit check_en = 1'b0;

   int n_checks = 0;
   int n_errs   = 0;

   string       lit_name [LITN];
   logic [31:0] lit_act  [LITN];
   logic [31:0] lit_exp  [LITN];
   int          lit_wr = 0;
   int          lit_rd = 0;

   int          resp_seen = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   int          last_rcyc = -1;

   lsu_mem_master #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_if    (bus),
      .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] preload(input int i);
      if (i == 4)  return 8'h80;
      if (i == 31) return 8'h34;
      if (i == 0)  return 8'h92;
      return 8'(32'hA0 + i);
   endfunction

   // Byte memory seen by the DUT: asynchronous read, write on posedge.
   assign mem_rdata = tb_mem[mem_addr];

   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < DEPTH; i++) tb_mem[i] <= preload(i);
      end else if (mem_wr_en === 1'b1) begin
         tb_mem[mem_addr] <= mem_wdata;
      end
   end

   // Model memory applies the writes the model expects.
   always @(posedge clk) begin
      if (cyc == 0) begin
         for (int i = 0; i < DEPTH; i++) model_mem[i] <= preload(i);
      end else if (cyc < MAXC && exp_wr[cyc]) begin
         model_mem[exp_addr[cyc]] <= exp_wdata[cyc];
      end
   end

   always @(negedge clk) begin
      if (bus.resp_valid === 1'b1) begin
         resp_seen  = resp_seen + 1;
         last_rdata = bus.resp_rdata;
         last_err   = bus.resp_err;
         last_rcyc  = cyc;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errs++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
      end
   endtask

   // Single compare process: drains literal pins, then checks outputs against the model.
   always @(negedge clk) begin
      while (lit_rd < lit_wr) begin
         chk(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
         lit_rd++;
      end
      if (check_en && cyc < MAXC) begin
         chk("req_ready",  32'(bus.req_ready),  32'(exp_ready[cyc]));
         chk("busy",       32'(bus.busy),       32'(exp_busy[cyc]));
         chk("mem_rd_en",  32'(mem_rd_en),      32'(exp_rd[cyc]));
         chk("mem_wr_en",  32'(mem_wr_en),      32'(exp_wr[cyc]));
         chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv[cyc]));
         if (exp_rd[cyc] || exp_wr[cyc]) chk("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
         if (exp_wr[cyc]) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata[cyc]));
         if (exp_rv[cyc]) begin
            chk("resp_rdata", bus.resp_rdata, exp_rdata[cyc]);
            chk("resp_err",   32'(bus.resp_err), 32'(exp_err[cyc]));
         end
      end
   end

   task automatic push(input string nm, input logic [31:0] act, input logic [31:0] req);
      if (lit_wr < LITN) begin
         lit_name[lit_wr] = nm;
         lit_act[lit_wr]  = act;
         lit_exp[lit_wr]  = req;
         lit_wr++;
      end
   endtask

   function automatic int nb(input logic [2:0] t);
      case (t)
         3'd0, 3'd3: return 1;
         3'd1, 3'd4: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit ok(input logic we, input logic [2:0] t);
      return (t <= 3'd4) && !(we && t >= 3'd3);
   endfunction

   function automatic logic [31:0] ext(input logic [2:0] t, input logic [31:0] raw);
      if (t == 3'd0) return raw[7]  ? (raw | 32'hFFFFFF00) : raw;
      if (t == 3'd1) return raw[15] ? (raw | 32'hFFFF0000) : raw;
      return raw;
   endfunction

   task automatic clear_from(input int from);
      for (int c = from; c < MAXC; c++) begin
         exp_ready[c] = 1'b1; exp_busy[c] = 1'b0; exp_rd[c] = 1'b0; exp_wr[c] = 1'b0;
         exp_addr[c] = '0; exp_wdata[c] = '0; exp_rv[c] = 1'b0; exp_err[c] = 1'b0;
         exp_rdata[c] = '0;
      end
   endtask

   // Transaction model: accepted at edge e, byte k in cycle e+k, response in cycle e+N.
   task automatic schedule(input int e, input logic we, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] d);
      int n;
      int ad;
      logic [31:0] raw;
      raw = '0;
      if (!ok(we, t)) begin
         exp_rv[e] = 1'b1; exp_err[e] = 1'b1; exp_rdata[e] = '0; exp_busy[e] = 1'b1;
         free_at = e;
         return;
      end
      n = nb(t);
      for (int k = 0; k < n; k++) begin
         ad = int'((a + 32'(k)) % 32'(DEPTH));
         exp_ready[e+k] = 1'b0;
         exp_busy[e+k]  = 1'b1;
         exp_rd[e+k]    = !we;
         exp_wr[e+k]    = we;
         exp_addr[e+k]  = AW'(ad);
         exp_wdata[e+k] = 8'(d >> (8 * k));
         if (!we) raw = raw | (32'(model_mem[ad]) << (8 * k));
      end
      exp_rv[e+n]    = 1'b1;
      exp_err[e+n]   = 1'b0;
      exp_rdata[e+n] = we ? 32'h0 : ext(t, raw);
      exp_busy[e+n]  = 1'b1;
      free_at = e + n;
   endtask

   // Present a request and hold it until the model says it is accepted; call at a negedge.
   task automatic send(input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, output int e);
      int guard;
      int c;
      guard = 0;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_type = t;
      bus.req_addr  = a;    bus.req_wdata = d;
      while (cyc < free_at && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) push("send_timeout", 32'(guard), 32'd0);
      c = cyc;
      @(posedge clk);
      e = c + 1;
      schedule(e, we, t, a, d);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom());
      bus.req_type  = 3'($urandom());
      bus.req_addr  = $urandom();
      bus.req_wdata = $urandom();
   endtask

   task automatic expect_resp(input string nm, input int s, input int e, input int lat,
                              input logic [31:0] rdata, input logic err);
      push({nm, "_count"}, 32'(resp_seen - s), 32'd1);
      push({nm, "_lat"},   32'(last_rcyc - e), 32'(lat));
      push({nm, "_rdata"}, last_rdata, rdata);
      push({nm, "_err"},   32'(last_err), 32'(err));
      push({nm, "_model"}, exp_rdata[e+lat], rdata);
   endtask

   initial begin
      int e;
      int e1;
      int s;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_type = '0;
      bus.req_addr  = '0;   bus.req_wdata = '0;
      clear_from(0);
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      push("rst_req_ready",  32'(bus.req_ready),  32'd1);
      push("rst_busy",       32'(bus.busy),       32'd0);
      push("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      push("rst_rd_en",      32'(mem_rd_en),      32'd0);
      push("rst_wr_en",      32'(mem_wr_en),      32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      s = resp_seen; send(1'b0, 3'd0, 32'd4, 32'h0, e);  repeat (4) @(negedge clk);
      expect_resp("lb4", s, e, 1, 32'hFFFFFF80, 1'b0);
      s = resp_seen; send(1'b0, 3'd3, 32'd4, 32'h0, e);  repeat (4) @(negedge clk);
      expect_resp("lbu4", s, e, 1, 32'h00000080, 1'b0);
      s = resp_seen; send(1'b0, 3'd1, 32'hFFFF_FFDF, 32'h0, e); repeat (5) @(negedge clk);
      expect_resp("lh31", s, e, 2, 32'hFFFF9234, 1'b0);
      s = resp_seen; send(1'b0, 3'd4, 32'd31, 32'h0, e); repeat (5) @(negedge clk);
      expect_resp("lhu31", s, e, 2, 32'h00009234, 1'b0);

      s = resp_seen; send(1'b1, 3'd2, 32'd4, 32'h8899AABB, e); repeat (7) @(negedge clk);
      expect_resp("sw4", s, e, 4, 32'h0, 1'b0);
      push("sw4_m4", 32'(tb_mem[4]), 32'hBB);
      push("sw4_m5", 32'(tb_mem[5]), 32'hAA);
      push("sw4_m6", 32'(tb_mem[6]), 32'h99);
      push("sw4_m7", 32'(tb_mem[7]), 32'h88);
      s = resp_seen; send(1'b0, 3'd2, 32'd4, 32'h0, e);  repeat (7) @(negedge clk);
      expect_resp("lw4", s, e, 4, 32'h8899AABB, 1'b0);

      s = resp_seen; send(1'b1, 3'd3, 32'd12, 32'h55, e); repeat (3) @(negedge clk);
      expect_resp("sbu_ill", s, e, 0, 32'h0, 1'b1);
      s = resp_seen; send(1'b1, 3'd4, 32'd12, 32'h55, e); repeat (3) @(negedge clk);
      expect_resp("shu_ill", s, e, 0, 32'h0, 1'b1);
      s = resp_seen; send(1'b0, 3'd5, 32'd12, 32'h0, e);  repeat (3) @(negedge clk);
      expect_resp("ld5_ill", s, e, 0, 32'h0, 1'b1);

      s = resp_seen;
      send(1'b1, 3'd0, 32'd10, 32'h0000005A, e1);
      send(1'b0, 3'd2, 32'd8, 32'h0, e);
      repeat (7) @(negedge clk);
      push("b2b_gap",   32'(e - e1),          32'd2);
      push("b2b_count", 32'(resp_seen - s),   32'd2);
      push("b2b_lat",   32'(last_rcyc - e),   32'd4);
      push("b2b_rdata", last_rdata,           32'hAB5AA9A8);

      s = resp_seen;
      send(1'b1, 3'd2, 32'd20, 32'h11223344, e);
      rst = 1'b1;
      clear_from(e + 1);
      free_at = e + 1;
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      push("rst_mid_count", 32'(resp_seen - s), 32'd0);
      push("rst_mid_m20",   32'(tb_mem[20]),    32'h44);
      push("rst_mid_m21",   32'(tb_mem[21]),    32'hB5);
      push("rst_mid_ready", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < DEPTH; i++) push($sformatf("mem_%0d", i), 32'(tb_mem[i]), 32'(model_mem[i]));
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
